// File: rtl/alu_arbiter.sv
// Purpose : shares one 32-bit ALU between execute (port 0) and branch/compare (port 1); optional round-robin via macro ALU_ARB_RR_EN.
// Latency : request accepted at edge E -> rsp_valid pulse visible after edge E+1 (issue reg + response reg).
// Backpr. : none downstream; both stages drain every cycle, so one request is accepted per cycle.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   req_valid/req_ready [1:0] per-requester handshake (bit i = requester i)
//   reqN_opA/opB/opcode/shamt requester operands, held stable while valid & !ready
//   alu_opA/opB/opcode/shamt  issue-register outputs feeding the external ALU
//   alu_result/ne/lt/ovf      combinational ALU results
//   rsp_valid [1:0]           one-cycle response pulse, one-hot by requester
//   rsp_result/ne/lt/ovf/err  registered response fields
// Build option: `define ALU_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req0_opA,
    input  logic [31:0] req0_opB,
    input  logic [4:0]  req0_opcode,
    input  logic [4:0]  req0_shamt,
    input  logic [31:0] req1_opA,
    input  logic [31:0] req1_opB,
    input  logic [4:0]  req1_opcode,
    input  logic [4:0]  req1_shamt,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_ne,
    input  logic        alu_lt,
    input  logic        alu_ovf,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_result,
    output logic        rsp_ne,
    output logic        rsp_lt,
    output logic        rsp_ovf,
    output logic        rsp_err
);

    // Opcodes 00000..00101 are legal; anything above is flagged as an error.
    localparam logic [4:0] OP_LAST_LEGAL = 5'd5;

    if (FIRST_PRIO > 1) begin : g_bad_first_prio
        $error("alu_arbiter: FIRST_PRIO must be 0 or 1");
    end

    // S0 arbitration
    logic [1:0]  win;
    logic        xfer;
    logic        gnt_id;
    logic [31:0] sel_opa;
    logic [31:0] sel_opb;
    logic [4:0]  sel_opc;
    logic [4:0]  sel_sh;
    logic        sel_err;

    // S1 issue register
    logic        iss_v_q,   iss_v_d;
    logic        iss_id_q,  iss_id_d;
    logic        iss_err_q, iss_err_d;
    logic [31:0] opa_q,     opa_d;
    logic [31:0] opb_q,     opb_d;
    logic [4:0]  opc_q,     opc_d;
    logic [4:0]  sh_q,      sh_d;

    // S2 response register
    logic [1:0]  rsp_valid_q,  rsp_valid_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_ne_q,     rsp_ne_d;
    logic        rsp_lt_q,     rsp_lt_d;
    logic        rsp_ovf_q,    rsp_ovf_d;
    logic        rsp_err_q,    rsp_err_d;

`ifdef ALU_ARB_RR_EN
    // Last-grant pointer: the other requester wins the next conflict.
    // Reset value makes FIRST_PRIO the winner of the first conflict.
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = gnt_id;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        win = req_valid;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            win = last_q ? 2'b01 : 2'b10;
`else
            win = 2'b01;
`endif
        end
    end

    // Grants are suppressed while reset is held so nothing is lost during reset.
    assign req_ready = win & {2{reset_n}};
    assign xfer      = |req_ready;
    assign gnt_id    = req_ready[1];

    always_comb begin
        if (gnt_id) begin
            sel_opa = req1_opA;
            sel_opb = req1_opB;
            sel_opc = req1_opcode;
            sel_sh  = req1_shamt;
        end else begin
            sel_opa = req0_opA;
            sel_opb = req0_opB;
            sel_opc = req0_opcode;
            sel_sh  = req0_shamt;
        end
        sel_err = (sel_opc > OP_LAST_LEGAL);
    end

    // S1: operands hold their last values when idle to avoid needless ALU toggling.
    always_comb begin
        iss_v_d   = xfer;
        iss_id_d  = iss_id_q;
        iss_err_d = iss_err_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        opc_d     = opc_q;
        sh_d      = sh_q;
        if (xfer) begin
            iss_id_d  = gnt_id;
            iss_err_d = sel_err;
            opa_d     = sel_opa;
            opb_d     = sel_opb;
            opc_d     = sel_err ? 5'd0 : sel_opc;
            sh_d      = sel_sh;
        end
    end

    // S2: capture ALU outputs; an illegal opcode returns zeros with err set.
    always_comb begin
        rsp_valid_d  = 2'b00;
        rsp_result_d = rsp_result_q;
        rsp_ne_d     = rsp_ne_q;
        rsp_lt_d     = rsp_lt_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        if (iss_v_q) begin
            rsp_valid_d = iss_id_q ? 2'b10 : 2'b01;
            if (iss_err_q) begin
                rsp_result_d = 32'd0;
                rsp_ne_d     = 1'b0;
                rsp_lt_d     = 1'b0;
                rsp_ovf_d    = 1'b0;
                rsp_err_d    = 1'b1;
            end else begin
                rsp_result_d = alu_result;
                rsp_ne_d     = alu_ne;
                rsp_lt_d     = alu_lt;
                rsp_ovf_d    = alu_ovf;
                rsp_err_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iss_v_q      <= 1'b0;
            iss_id_q     <= 1'b0;
            iss_err_q    <= 1'b0;
            opa_q        <= 32'd0;
            opb_q        <= 32'd0;
            opc_q        <= 5'd0;
            sh_q         <= 5'd0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= 32'd0;
            rsp_ne_q     <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            iss_v_q      <= iss_v_d;
            iss_id_q     <= iss_id_d;
            iss_err_q    <= iss_err_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opc_q        <= opc_d;
            sh_q         <= sh_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_ne_q     <= rsp_ne_d;
            rsp_lt_q     <= rsp_lt_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_opA    = opa_q;
    assign alu_opB    = opb_q;
    assign alu_opcode = opc_q;
    assign alu_shamt  = sh_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_ne     = rsp_ne_q;
    assign rsp_lt     = rsp_lt_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_err    = rsp_err_q;

endmodule
